// File: rtl/dut_seq_pkg.sv
// Shared types and defaults for the stimulus sequencer slice.
// Optional feature macro used by the top: DUT_SEQ_SIGNATURE_EN.
package dut_seq_pkg;

  localparam int WORD_W_DEF        = 32;
  localparam int NUM_WORDS_DEF     = 3;
  localparam int SETTLE_CYCLES_DEF = 2;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STREAM = 2'd2
  } state_e;

  typedef logic [IDX_W_DEF-1:0] word_idx_t;

endpackage

// File: rtl/dut_seq_rsp_serializer.sv
// Response stage: captures the packed DUT output in one shot and streams it
// back one word at a time over a valid/ready handshake. Word k of the
// capture is bits [k*WORD_W +: WORD_W].
module dut_seq_rsp_serializer
  import dut_seq_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int IDX_W     = idx_width(NUM_WORDS_DEF)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        capture_i,
  input  logic [NUM_WORDS*WORD_W-1:0] cap_data_i,
  input  logic                        rsp_ready_i,
  output logic                        rsp_valid_o,
  output logic [IDX_W-1:0]            rsp_idx_o,
  output logic [WORD_W-1:0]           rsp_data_o,
  output logic                        rsp_last_o,
  output logic                        rsp_done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [NUM_WORDS*WORD_W-1:0] r_cap;
  logic                        r_valid;
  logic [IDX_W-1:0]            r_idx;
  logic                        w_hs;
  logic                        w_at_last;
  logic [WORD_W-1:0]           w_data;

  assign w_hs      = r_valid & rsp_ready_i;
  assign w_at_last = (r_idx == LAST_IDX);

  // Capture the response, then advance the word index on every handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cap   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (capture_i) begin
      r_cap   <= cap_data_i;
      r_valid <= 1'b1;
      r_idx   <= '0;
    end else if (w_hs) begin
      if (w_at_last) begin
        r_valid <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  // Select the captured word addressed by the current index (one-hot OR mux).
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_data = w_data | ({WORD_W{r_idx == IDX_W'(k)}} & r_cap[k*WORD_W +: WORD_W]);
    end
  end

  assign rsp_valid_o = r_valid;
  assign rsp_idx_o   = r_idx;
  assign rsp_data_o  = w_data;
  assign rsp_last_o  = w_at_last;
  assign rsp_done_o  = w_hs & w_at_last;

endmodule

// File: rtl/dut_stim_sequencer.sv
// Stimulus sequencer: stages NUM_WORDS input words, applies them as one packed
// vector to the DUT under fuzz, waits SETTLE_CYCLES, captures the packed
// response and streams it back word by word.
// Optional feature: define DUT_SEQ_SIGNATURE_EN to add the sig_o response
// signature (rotate-left-by-one then XOR with each accepted response word).
module dut_stim_sequencer
  import dut_seq_pkg::*;
#(
  parameter  int WORD_W        = WORD_W_DEF,
  parameter  int NUM_WORDS     = NUM_WORDS_DEF,
  parameter  int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  localparam int IDX_W         = idx_width(NUM_WORDS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [WORD_W-1:0]           wr_data_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic [NUM_WORDS*WORD_W-1:0] dut_in_o,
  input  logic [NUM_WORDS*WORD_W-1:0] dut_out_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [IDX_W-1:0]            rsp_idx_o,
  output logic [WORD_W-1:0]           rsp_data_o,
  output logic                        rsp_last_o
`ifdef DUT_SEQ_SIGNATURE_EN
  ,
  output logic [WORD_W-1:0]           sig_o
`endif
);

  localparam int VEC_W = NUM_WORDS * WORD_W;
  localparam int CNT_W = idx_width(SETTLE_CYCLES + 1);

  state_e            r_state;
  logic [VEC_W-1:0]  r_staging;
  logic [VEC_W-1:0]  r_dut_in;
  logic [CNT_W-1:0]  r_cnt;
  logic [VEC_W-1:0]  w_staging_next;
  logic              w_wr_en;
  logic              w_capture;
  logic              w_rsp_done;

  // Writes are only taken while idle; out-of-range slots match no word.
  assign w_wr_en   = wr_valid_i & (r_state == IDLE);
  assign w_capture = (r_state == SETTLE) && (r_cnt == '0);

  // Staging image after this cycle's write, so a same-cycle start sees it.
  always_comb begin
    w_staging_next = r_staging;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_staging_next[k*WORD_W +: WORD_W] =
        (w_wr_en && (wr_idx_i == IDX_W'(k))) ? wr_data_i : r_staging[k*WORD_W +: WORD_W];
    end
  end

  // Sequencing FSM: apply vector, count settle time, wait for stream to finish.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_staging <= '0;
      r_dut_in  <= '0;
      r_cnt     <= '0;
    end else begin
      r_staging <= w_staging_next;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_dut_in <= w_staging_next;
            r_cnt    <= CNT_W'(SETTLE_CYCLES);
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_rsp_done) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  dut_seq_rsp_serializer #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_rsp (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .capture_i   (w_capture),
    .cap_data_i  (dut_out_i),
    .rsp_ready_i (rsp_ready_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_idx_o   (rsp_idx_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_last_o  (rsp_last_o),
    .rsp_done_o  (w_rsp_done)
  );

`ifdef DUT_SEQ_SIGNATURE_EN
  logic [WORD_W-1:0] r_sig;
  logic              w_rsp_hs;

  assign w_rsp_hs = rsp_valid_o & rsp_ready_i;

  // Fold every accepted response word into the running signature.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sig <= '0;
    end else if (w_rsp_hs) begin
      r_sig <= {r_sig[WORD_W-2:0], r_sig[WORD_W-1]} ^ rsp_data_o;
    end
  end

  assign sig_o = r_sig;
`endif

  assign dut_in_o   = r_dut_in;
  assign busy_o     = (r_state != IDLE);
  assign wr_ready_o = (r_state == IDLE);

endmodule

// File: tb/tb_dut_stim_sequencer.sv
// Self-checking bench for dut_stim_sequencer (default parameters).
// Build with DUT_SEQ_SIGNATURE_EN defined to also exercise sig_o.
`timescale 1ns/1ps
module tb_dut_stim_sequencer;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 3;
  localparam int IDX_W     = 2;
  localparam int VEC_W     = 96;
  localparam int SETTLE    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_idx = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic              busy;
  logic [VEC_W-1:0]  dut_in;
  logic [VEC_W-1:0]  dut_out;
  logic [VEC_W-1:0]  xor_mask = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDX_W-1:0]  rsp_idx;
  logic [WORD_W-1:0] rsp_data;
  logic              rsp_last;
`ifdef DUT_SEQ_SIGNATURE_EN
  logic [WORD_W-1:0] sig;
`endif

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
    logic              last;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] model_stage [NUM_WORDS];
  logic [31:0] model_sig = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Model of the DUT under fuzz: identity, optionally XOR-scrambled.
  assign dut_out = dut_in ^ xor_mask;

  always #5 clk = ~clk;

  dut_stim_sequencer u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_idx_i    (wr_idx),
    .wr_data_i   (wr_data),
    .start_i     (start),
    .busy_o      (busy),
    .dut_in_o    (dut_in),
    .dut_out_i   (dut_out),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_idx_o   (rsp_idx),
    .rsp_data_o  (rsp_data),
    .rsp_last_o  (rsp_last)
`ifdef DUT_SEQ_SIGNATURE_EN
    ,
    .sig_o       (sig)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] model_vec();
    return {model_stage[2], model_stage[1], model_stage[0]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM_WORDS; k++) model_stage[k] = '0;
    model_sig = '0;
    exp_q.delete();
  endtask

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [31:0] data);
    wr_valid = 1'b1; wr_idx = idx; wr_data = data;
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL wr_ready_idle: got %b expected 1", wr_ready);
    else n_pass++;
    tick();
    wr_valid = 1'b0;
    if (idx < IDX_W'(NUM_WORDS)) model_stage[idx] = data;
  endtask

  // Start a vector, optionally with a same-cycle write, and queue its response.
  task automatic do_start(input bit with_wr, input logic [IDX_W-1:0] idx, input logic [31:0] data);
    logic [VEC_W-1:0] v;
    rsp_t e;
    start = 1'b1;
    if (with_wr) begin
      wr_valid = 1'b1; wr_idx = idx; wr_data = data;
      if (idx < IDX_W'(NUM_WORDS)) model_stage[idx] = data;
    end
    v = model_vec() ^ xor_mask;
    for (int k = 0; k < NUM_WORDS; k++) begin
      e.idx = IDX_W'(k); e.data = v[k*WORD_W +: WORD_W]; e.last = (k == NUM_WORDS - 1);
      exp_q.push_back(e);
    end
    tick();
    start = 1'b0; wr_valid = 1'b0;
    n_checks++;
    if (dut_in !== model_vec()) $display("FAIL dut_in_applied: got %h expected %h", dut_in, model_vec());
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) $display("FAIL busy_after_start: got busy=%b wr_ready=%b expected 1/0", busy, wr_ready);
    else n_pass++;
  endtask

  // Consume one queued response; optional stall before stall_word and pokes of start/write.
  task automatic drain(input int stall_word, input int stall_len, input bit poke);
    int n;
    rsp_t e;
    n = 0;
    rsp_ready = 1'b0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      if (poke && n == 0) begin
        start = 1'b1; wr_valid = 1'b1; wr_idx = '0; wr_data = 32'hFFFF_FFFF;
        n_checks++;
        if (wr_ready !== 1'b0) $display("FAIL wr_ready_settle: got %b expected 0", wr_ready);
        else n_pass++;
      end
      tick();
      n++;
      start = 1'b0; wr_valid = 1'b0;
    end
    n_checks++;
    if (n != SETTLE + 1) $display("FAIL rsp_latency: got %0d cycles expected %0d", n, SETTLE + 1);
    else n_pass++;
    if (rsp_valid !== 1'b1) begin
      exp_q.delete();
      return;
    end
    for (int w = 0; w < NUM_WORDS; w++) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
        break;
      end
      n_pass++;
      e = exp_q.pop_front();
      if (w == stall_word) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          n_checks++;
          if (rsp_valid !== 1'b1 || rsp_idx !== e.idx || rsp_data !== e.data)
            $display("FAIL stall_stable: got v=%b idx=%0d data=%h expected v=1 idx=%0d data=%h",
                     rsp_valid, rsp_idx, rsp_data, e.idx, e.data);
          else n_pass++;
        end
      end
      rsp_ready = 1'b1;
      if (poke && w == 0) begin
        start = 1'b1; wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 32'hFFFF_FFFF;
        n_checks++;
        if (wr_ready !== 1'b0) $display("FAIL wr_ready_stream: got %b expected 0", wr_ready);
        else n_pass++;
      end
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_idx !== e.idx || rsp_data !== e.data || rsp_last !== e.last)
        $display("FAIL rsp_word%0d: got v=%b idx=%0d data=%h last=%b expected v=1 idx=%0d data=%h last=%b",
                 w, rsp_valid, rsp_idx, rsp_data, rsp_last, e.idx, e.data, e.last);
      else n_pass++;
      tick();
      rsp_ready = 1'b0; start = 1'b0; wr_valid = 1'b0;
`ifdef DUT_SEQ_SIGNATURE_EN
      model_sig = {model_sig[30:0], model_sig[31]} ^ e.data;
      n_checks++;
      if (sig !== model_sig) $display("FAIL sig_word%0d: got %h expected %h", w, sig, model_sig);
      else n_pass++;
`endif
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1)
      $display("FAIL stream_end: got v=%b busy=%b wr_ready=%b expected 0/0/1", rsp_valid, busy, wr_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_in !== '0 || rsp_valid !== 1'b0 || rsp_idx !== '0 || rsp_data !== '0 || busy !== 1'b0)
      $display("FAIL reset_state: got dut_in=%h v=%b idx=%0d data=%h busy=%b expected all 0",
               dut_in, rsp_valid, rsp_idx, rsp_data, busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (wr_ready !== 1'b1) $display("FAIL reset_idle: got wr_ready=%b expected 1", wr_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_write(2'd0, 32'h0002_0000);
    do_write(2'd1, 32'h0);
    do_write(2'd2, 32'h0);
    do_start(1'b0, '0, '0);
    n_checks++;
    if (dut_in !== 96'h0000_0000_0000_0000_0002_0000)
      $display("FAIL basic_dut_in: got %h expected 000000000000000000020000", dut_in);
    else n_pass++;
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_write(2'd1, 32'hA5A5_0001);
    do_write(2'd2, 32'h1234_5678);
    do_start(1'b0, '0, '0);
    drain(1, 5, 1'b0);
  endtask

  task automatic test_write_start_same_cycle();
    do_start(1'b1, 2'd2, 32'hDEAD_BEEF);
    n_checks++;
    if (dut_in[95:64] !== 32'hDEAD_BEEF) $display("FAIL wr_start_word2: got %h expected deadbeef", dut_in[95:64]);
    else n_pass++;
    drain(0, 2, 1'b0);
  endtask

  task automatic test_oob_and_scramble();
    do_write(2'd3, 32'h5555_5555);
    do_write(2'd0, 32'h0BAD_F00D);
    xor_mask = 96'h0F0F_0F0F_3C3C_3C3C_FFFF_0000;
    do_start(1'b0, '0, '0);
    drain(2, 1, 1'b0);
    xor_mask = '0;
  endtask

  task automatic test_ignored_inputs();
    do_start(1'b0, '0, '0);
    drain(-1, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_response: got v=%b busy=%b expected 0/0", rsp_valid, busy);
      else n_pass++;
    end
    do_start(1'b0, '0, '0);
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    int n;
    do_write(2'd0, 32'h1111_2222);
    do_start(1'b0, '0, '0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (rsp_valid !== 1'b1) $display("FAIL mid_reset_wait: got v=%b expected 1", rsp_valid);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_in !== '0 || rsp_valid !== 1'b0 || rsp_idx !== '0 || rsp_data !== '0 || rsp_last !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset_outputs: got dut_in=%h v=%b idx=%0d data=%h last=%b busy=%b expected all 0",
               dut_in, rsp_valid, rsp_idx, rsp_data, rsp_last, busy);
    else n_pass++;
`ifdef DUT_SEQ_SIGNATURE_EN
    n_checks++;
    if (sig !== '0) $display("FAIL mid_reset_sig: got %h expected 0", sig);
    else n_pass++;
`endif
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_reset_idle: got wr_ready=%b busy=%b expected 1/0", wr_ready, busy);
    else n_pass++;
    do_start(1'b0, '0, '0);
    drain(-1, 0, 1'b0);
  endtask

`ifdef DUT_SEQ_SIGNATURE_EN
  task automatic test_signature();
    do_write(2'd0, 32'h1);
    do_write(2'd1, 32'h2);
    do_write(2'd2, 32'h4);
    do_start(1'b0, '0, '0);
    drain(-1, 0, 1'b0);
    n_checks++;
    if (sig !== 32'h4) $display("FAIL sig_final: got %h expected 00000004", sig);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_write_start_same_cycle();
    test_oob_and_scramble();
    test_ignored_inputs();
    test_reset_mid_stream();
`ifdef DUT_SEQ_SIGNATURE_EN
    test_signature();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
